// File: rtl/cr_input_pkg.sv
// cr_input_pkg: shared constants, types and helpers for the keyboard input path.
//   - HID usage codes for the fixed key map
//   - dir_t one-hot direction encoding {Right,Left,Down,Up}
//   - repeat_state_t for the per-player hold-to-repeat FSM
//   - report decode / ErrorRollOver detect / direction priority helpers
package cr_input_pkg;

    // Report geometry
    localparam int unsigned SLOT_W    = 8;
    localparam int unsigned NUM_SLOTS = 4;
    localparam int unsigned REPORT_W  = SLOT_W * NUM_SLOTS;

    // Held vector layout: [3:0] P1 {R,L,D,U}, [7:4] P2 {R,L,D,U}, [8] Enter
    localparam int unsigned DIR_W      = 4;
    localparam int unsigned HELD_W     = 2 * DIR_W + 1;
    localparam int unsigned HELD_P1_LSB = 0;
    localparam int unsigned HELD_P2_LSB = DIR_W;
    localparam int unsigned HELD_ENTER  = 2 * DIR_W;

    // Direction bit positions inside a 4-bit group
    localparam int unsigned DIR_BIT_UP    = 0;
    localparam int unsigned DIR_BIT_DOWN  = 1;
    localparam int unsigned DIR_BIT_LEFT  = 2;
    localparam int unsigned DIR_BIT_RIGHT = 3;

    // Repeat counter
    localparam int unsigned CNT_W = 6;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(63);

    // HID usage codes
    localparam logic [SLOT_W-1:0] KC_NONE     = 8'h00;
    localparam logic [SLOT_W-1:0] KC_ROLLOVER = 8'h01;
    localparam logic [SLOT_W-1:0] KC_A        = 8'h04;
    localparam logic [SLOT_W-1:0] KC_D        = 8'h07;
    localparam logic [SLOT_W-1:0] KC_S        = 8'h16;
    localparam logic [SLOT_W-1:0] KC_W        = 8'h1A;
    localparam logic [SLOT_W-1:0] KC_ENTER    = 8'h28;
    localparam logic [SLOT_W-1:0] KC_RIGHT    = 8'h4F;
    localparam logic [SLOT_W-1:0] KC_LEFT     = 8'h50;
    localparam logic [SLOT_W-1:0] KC_DOWN     = 8'h51;
    localparam logic [SLOT_W-1:0] KC_UP       = 8'h52;

    typedef enum logic [DIR_W-1:0] {
        DIR_NONE  = 4'b0000,
        DIR_UP    = 4'b0001,
        DIR_DOWN  = 4'b0010,
        DIR_LEFT  = 4'b0100,
        DIR_RIGHT = 4'b1000
    } dir_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } repeat_state_t;

    // True if any slot carries ErrorRollOver; such reports are dropped whole.
    function automatic logic has_rollover(input logic [REPORT_W-1:0] report);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (report[i*SLOT_W +: SLOT_W] == KC_ROLLOVER) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    // Map every slot onto the held vector; zero/unmapped slots fall through.
    function automatic logic [HELD_W-1:0] decode_report(input logic [REPORT_W-1:0] report);
        logic [HELD_W-1:0] held;
        logic [SLOT_W-1:0] kc;
        held = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            kc = report[i*SLOT_W +: SLOT_W];
            case (kc)
                KC_W:     held[HELD_P1_LSB + DIR_BIT_UP]    = 1'b1;
                KC_S:     held[HELD_P1_LSB + DIR_BIT_DOWN]  = 1'b1;
                KC_A:     held[HELD_P1_LSB + DIR_BIT_LEFT]  = 1'b1;
                KC_D:     held[HELD_P1_LSB + DIR_BIT_RIGHT] = 1'b1;
                KC_UP:    held[HELD_P2_LSB + DIR_BIT_UP]    = 1'b1;
                KC_DOWN:  held[HELD_P2_LSB + DIR_BIT_DOWN]  = 1'b1;
                KC_LEFT:  held[HELD_P2_LSB + DIR_BIT_LEFT]  = 1'b1;
                KC_RIGHT: held[HELD_P2_LSB + DIR_BIT_RIGHT] = 1'b1;
                KC_ENTER: held[HELD_ENTER]                  = 1'b1;
                default:  ;
            endcase
        end
        return held;
    endfunction

    // Highest-priority held direction: Up > Down > Left > Right.
    function automatic dir_t pick_dir(input logic [DIR_W-1:0] dirs);
        dir_t d;
        if (dirs[DIR_BIT_UP]) begin
            d = DIR_UP;
        end else if (dirs[DIR_BIT_DOWN]) begin
            d = DIR_DOWN;
        end else if (dirs[DIR_BIT_LEFT]) begin
            d = DIR_LEFT;
        end else if (dirs[DIR_BIT_RIGHT]) begin
            d = DIR_RIGHT;
        end else begin
            d = DIR_NONE;
        end
        return d;
    endfunction

endpackage

// File: rtl/key_repeat_fsm.sv
// key_repeat_fsm: per-player hold-to-repeat logic, advanced once per frame tick.
//   Clk   in  1  system clock
//   Reset in  1  asynchronous active-low reset
//   tick  in  1  one-Clk frame pulse
//   held  in  4  held directions {R,L,D,U}
//   Move  out 4  registered one-hot step request, held for the whole frame
module key_repeat_fsm
    import cr_input_pkg::*;
#(
    parameter int unsigned REPEAT_DELAY = 12,
    parameter int unsigned REPEAT_RATE  = 6
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             tick,
    input  logic [DIR_W-1:0] held,
    output logic [DIR_W-1:0] Move
);

    localparam logic [CNT_W-1:0] DELAY_CNT = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] RATE_CNT  = CNT_W'(REPEAT_RATE);

    repeat_state_t     state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    dir_t              dir_q, dir_d;
    dir_t              move_q, move_d;

    dir_t              cur;
    logic [CNT_W-1:0]  cnt_inc;

    // State register
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dir_q   <= DIR_NONE;
            move_q  <= DIR_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            move_q  <= move_d;
        end
    end

    // Next state; everything holds between ticks so Move is stable for the frame
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        move_d  = move_q;
        cur     = pick_dir(held);
        cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

        if (tick) begin
            move_d = DIR_NONE;
            case (state_q)
                IDLE: begin
                    if (cur != DIR_NONE) begin
                        move_d  = cur;
                        cnt_d   = '0;
                        dir_d   = cur;
                        state_d = DELAY;
                    end
                end
                DELAY, REPEAT: begin
                    if (cur == DIR_NONE) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        dir_d   = DIR_NONE;
                    end else if (cur != dir_q) begin
                        // New winning direction restarts the initial delay
                        move_d  = cur;
                        cnt_d   = '0;
                        dir_d   = cur;
                        state_d = DELAY;
                    end else if (state_q == DELAY && cnt_inc == DELAY_CNT) begin
                        move_d  = cur;
                        cnt_d   = '0;
                        state_d = REPEAT;
                    end else if (state_q == REPEAT && cnt_inc == RATE_CNT) begin
                        move_d  = cur;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_inc;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    dir_d   = DIR_NONE;
                end
            endcase
        end
    end

    assign Move = move_q;

endmodule

// File: rtl/keycode_decoder.sv
// keycode_decoder: turns SoC HID keycode reports into per-player, frame-aligned
// step requests and a Continue request.
//   Clk         in  1   system clock
//   Reset       in  1   asynchronous active-low reset
//   FrameClk    in  1   VGA_VS, asynchronous, active-low sync pulse
//   KeyStrobe   in  1   one-Clk pulse when a new report is written
//   Keycodes    in  32  four HID usage slots, slot i = [8i+7:8i]
//   P1Move      out 4   one-hot {R,L,D,U} step request, player 1
//   P2Move      out 4   same for player 2
//   ContinueReq out 1   Enter newly pressed this frame
//   Held        out 9   current pressed-key vector
module keycode_decoder
    import cr_input_pkg::*;
#(
    parameter int unsigned REPEAT_DELAY = 12,
    parameter int unsigned REPEAT_RATE  = 6
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                FrameClk,
    input  logic                KeyStrobe,
    input  logic [REPORT_W-1:0] Keycodes,
    output logic [DIR_W-1:0]    P1Move,
    output logic [DIR_W-1:0]    P2Move,
    output logic                ContinueReq,
    output logic [HELD_W-1:0]   Held
);

    logic [REPORT_W-1:0] report_q;
    logic [HELD_W-1:0]   held_q;
    logic                fs_meta_q;
    logic                fs_sync_q;
    logic                fs_prev_q;
    logic                tick;
    logic                enter_prev_q;
    logic                continue_q;

    // Report latch; a report flagged ErrorRollOver leaves the previous one in place
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            report_q <= '0;
        end else if (KeyStrobe && !has_rollover(Keycodes)) begin
            report_q <= Keycodes;
        end
    end

    // Held vector, one cycle behind the report latch
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            held_q <= '0;
        end else begin
            held_q <= decode_report(report_q);
        end
    end

    // FrameClk synchronizer plus edge flop; all idle high to match VS idle level
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            fs_meta_q <= 1'b1;
            fs_sync_q <= 1'b1;
            fs_prev_q <= 1'b1;
        end else begin
            fs_meta_q <= FrameClk;
            fs_sync_q <= fs_meta_q;
            fs_prev_q <= fs_sync_q;
        end
    end

    // Start of vsync pulse
    assign tick = fs_prev_q & ~fs_sync_q;

    // Enter edge detect, sampled only at ticks so it never repeats
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            enter_prev_q <= 1'b0;
            continue_q   <= 1'b0;
        end else if (tick) begin
            continue_q   <= held_q[HELD_ENTER] & ~enter_prev_q;
            enter_prev_q <= held_q[HELD_ENTER];
        end
    end

    key_repeat_fsm #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    ) u_p1_fsm (
        .Clk   (Clk),
        .Reset (Reset),
        .tick  (tick),
        .held  (held_q[HELD_P1_LSB +: DIR_W]),
        .Move  (P1Move)
    );

    key_repeat_fsm #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    ) u_p2_fsm (
        .Clk   (Clk),
        .Reset (Reset),
        .tick  (tick),
        .held  (held_q[HELD_P2_LSB +: DIR_W]),
        .Move  (P2Move)
    );

    assign ContinueReq = continue_q;
    assign Held        = held_q;

endmodule

// File: tb/tb_keycode_decoder.sv
// Directed bench for keycode_decoder with REPEAT_DELAY=3, REPEAT_RATE=2.
module tb_keycode_decoder;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        FrameClk;
    logic        KeyStrobe;
    logic [31:0] Keycodes;
    logic [3:0]  P1Move;
    logic [3:0]  P2Move;
    logic        ContinueReq;
    logic [8:0]  Held;

    int n_checks = 0;
    int n_pass   = 0;

    keycode_decoder #(
        .REPEAT_DELAY (3),
        .REPEAT_RATE  (2)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .FrameClk    (FrameClk),
        .KeyStrobe   (KeyStrobe),
        .Keycodes    (Keycodes),
        .P1Move      (P1Move),
        .P2Move      (P2Move),
        .ContinueReq (ContinueReq),
        .Held        (Held)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Advance to 1ns after the next rising edge
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic strobe(input logic [31:0] kc);
        Keycodes  = kc;
        KeyStrobe = 1'b1;
        step();
        KeyStrobe = 1'b0;
    endtask

    // One frame: 4-cycle low sync pulse then 6 idle cycles
    task automatic frame();
        FrameClk = 1'b0;
        repeat (4) step();
        FrameClk = 1'b1;
        repeat (6) step();
    endtask

    // Frame whose strobe lands one cycle before the tick
    task automatic frame_late(input logic [31:0] kc);
        FrameClk = 1'b0;
        step();
        strobe(kc);
        repeat (2) step();
        FrameClk = 1'b1;
        repeat (6) step();
    endtask

    initial begin
        Reset     = 1'b0;
        FrameClk  = 1'b1;
        KeyStrobe = 1'b0;
        Keycodes  = '0;
        repeat (3) step();
        chk("rst_p1", 9'(P1Move), 9'h0);
        chk("rst_p2", 9'(P2Move), 9'h0);
        chk("rst_cont", 9'(ContinueReq), 9'h0);
        chk("rst_held", Held, 9'h0);
        Reset = 1'b1;
        repeat (2) step();

        // Single W press: one step, then release
        strobe(32'h0000_001A);
        step();
        chk("w_held", Held, 9'h001);
        frame();
        chk("w_p1", 9'(P1Move), 9'h001);
        chk("w_p2", 9'(P2Move), 9'h000);
        strobe(32'h0);
        frame();
        chk("w_rel_p1", 9'(P1Move), 9'h000);

        // P2 Up held: steps at frames 0,3,5,7
        strobe(32'h0000_0052);
        for (int f = 0; f < 9; f++) begin
            frame();
            chk($sformatf("p2_rep_f%0d", f), 9'(P2Move),
                (f == 0 || f == 3 || f == 5 || f == 7) ? 9'h001 : 9'h000);
        end
        chk("p2_rep_p1", 9'(P1Move), 9'h000);

        // Priority: S+W for P1, Left+Right for P2
        strobe(32'h161A_504F);
        step();
        chk("prio_held", Held, 9'h0C3);
        frame();
        chk("prio_p1", 9'(P1Move), 9'h001);
        chk("prio_p2", 9'(P2Move), 9'h004);
        strobe(32'h0);
        frame();
        chk("prio_rel_p1", 9'(P1Move), 9'h000);
        chk("prio_rel_p2", 9'(P2Move), 9'h000);

        // Enter held 5 frames, release, press again
        strobe(32'h0000_0028);
        for (int f = 0; f < 5; f++) begin
            frame();
            chk($sformatf("enter_f%0d", f), 9'(ContinueReq), (f == 0) ? 9'h1 : 9'h0);
        end
        chk("enter_p1", 9'(P1Move), 9'h000);
        strobe(32'h0);
        frame();
        chk("enter_rel", 9'(ContinueReq), 9'h0);
        strobe(32'h0000_0028);
        frame();
        chk("enter_again", 9'(ContinueReq), 9'h1);
        strobe(32'h0);
        frame();
        chk("enter_again_rel", 9'(ContinueReq), 9'h0);

        // ErrorRollOver report discarded; W keeps repeating on schedule
        strobe(32'h0000_001A);
        frame();
        chk("ro_f0", 9'(P1Move), 9'h001);
        strobe(32'h0000_0001);
        step();
        chk("ro_held", Held, 9'h001);
        for (int f = 1; f < 6; f++) begin
            frame();
            chk($sformatf("ro_f%0d", f), 9'(P1Move),
                (f == 3 || f == 5) ? 9'h001 : 9'h000);
        end

        // Strobe one cycle before the tick: S seen only the frame after
        frame_late(32'h0000_0016);
        chk("late_same", 9'(P1Move), 9'h000);
        frame();
        chk("late_next", 9'(P1Move), 9'h002);

        // Reset mid-frame while P1 is in DELAY
        Reset = 1'b0;
        step();
        chk("mrst_p1", 9'(P1Move), 9'h000);
        chk("mrst_held", Held, 9'h000);
        Reset = 1'b1;
        step();
        strobe(32'h0000_0016);
        frame();
        chk("mrst_first", 9'(P1Move), 9'h002);
        frame();
        chk("mrst_second", 9'(P1Move), 9'h000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/keycode_decoder.md
# keycode_decoder

Converts the raw USB HID keycode report written by the SoC into per-player, frame-aligned movement requests and a Continue request. Sits between the SoC keycode PIO and the two player instances. Owns key-press edge detection, hold-to-repeat timing and direction priority. Its outputs are stable across the VGA_VS rising edge that clocks the players.

## Interface
- REPEAT_DELAY, default 12: frames a direction must be held before the first auto-repeat (1..63).
- REPEAT_RATE, default 6: frames between subsequent auto-repeats (1..63).
- Clk  in  1  system clock (MAX10_CLK1_50).
- Reset  in  1  asynchronous, active-low reset.
- FrameClk  in  1  VGA_VS, asynchronous to Clk, active-low sync pulse.
- KeyStrobe  in  1  one-Clk pulse: SoC has written a new report.
- Keycodes  in  32  four 8-bit HID usage slots; slot i = bits [8i+7:8i].
- P1Move  out  4  one-hot {Right,Left,Down,Up} step request for player 1; 0 = none.
- P2Move  out  4  same encoding for player 2.
- ContinueReq  out  1  Enter newly pressed this frame.
- Held  out  9  debug: current pressed-key vector.

## Operation
- Key map, fixed:
  - P1: W=0x1A, S=0x16, A=0x04, D=0x07.
  - P2: Up=0x52, Down=0x51, Left=0x50, Right=0x4F.
  - Enter=0x28.
- Report latch:
  - On KeyStrobe, Keycodes is registered.
  - If any slot = 0x01 (ErrorRollOver), the whole report is discarded and the previous report is kept.
  - Slots holding 0x00 or an unmapped code are ignored; duplicate codes across slots are harmless.
- Held vector: 9 bits (P1 U/D/L/R, P2 U/D/L/R, Enter), registered from the latched report.
- Frame tick:
  - FrameClk passes through a 2-flop synchronizer plus an edge flop.
  - Tick = one-Clk pulse on the synchronized falling edge (start of the vsync pulse).
- Per-player FSM, evaluated only on tick. The direction d is the highest-priority held direction, priority Up > Down > Left > Right.
  - IDLE: if none held, Move=0. Otherwise emit d, cnt=0, go to DELAY.
  - DELAY: if none held → IDLE, Move=0. Else cnt+1. When cnt reaches REPEAT_DELAY, emit d, cnt=0, go to REPEAT. Otherwise Move=0.
  - REPEAT: if none held → IDLE. Else cnt+1. When cnt reaches REPEAT_RATE, emit d and set cnt=0. Otherwise Move=0.
  - A change of d while in DELAY or REPEAT: emit the new d immediately, cnt=0, go to DELAY.
- ContinueReq = Enter held now AND Enter not held at the previous tick. Enter never repeats.
- Outputs are registered. They change only in the Clk cycle after a tick and hold their value for the entire frame.
- Counters are 6-bit and saturate at 63.

## Timing
- Reset values: P1Move=0, P2Move=0, ContinueReq=0, Held=0, both FSMs IDLE, counters 0, latched report 0, synchronizer flops 1 (FrameClk idles high).
- Strobe to Held: KeyStrobe at cycle t → report register at t+1 → Held at t+2.
- Strobe too close to a tick: a strobe at t is reflected at a tick in cycle k only if t+2 ≤ k. Otherwise it is reflected at the next frame.
- FrameClk falling edge → tick in 3–4 Clk cycles → outputs 1 cycle later. That is at most 5 cycles after sync start, far ahead of the VS rising edge roughly 3200 cycles later.
- Simultaneous KeyStrobe and tick: tick evaluation uses the pre-strobe Held.
- Reset asserted mid-frame clears all state immediately. The first tick after deassertion behaves as from IDLE, so a key already held produces a step.
- No handshake back to the SoC. Reports may be overwritten at any rate; only the last one before each tick matters.

## Structure
- Package cr_input_pkg holds:
  - keycode constants (KC_W … KC_ENTER);
  - dir_t one-hot enum (DIR_NONE, DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT);
  - repeat_state_t enum (IDLE, DELAY, REPEAT).
- Sub-module key_repeat_fsm: one instance per player. Inputs are Clk, Reset, tick and the 4-bit held directions; output is the 4-bit Move; it carries both parameters.
- The top level owns the report latch, slot decode, synchronizer and Enter edge detect.

## Test plan
- Reset → all outputs 0. Strobe 0x0000001A, then one FrameClk low pulse → P1Move=0001 for exactly one frame, P2Move=0000.
- Hold 0x52 with REPEAT_DELAY=3, REPEAT_RATE=2 → P2Move=0001 at frames 0, 3, 5, 7; 0000 in every other frame.
- Report 0x16_1A_50_4F → P1Move=0001 (Up beats Down), P2Move=0100 (Left beats Right).
- Enter held for 5 frames → ContinueReq high in the first frame only. Release then press again → high once more.
- Report 0x00000001 after 0x0000001A → discarded; P1 keeps repeating Up on schedule.
- Strobe exactly one cycle before the tick → change seen at the following frame. Reset pulsed during DELAY → outputs 0 at once, IDLE on the next tick.
